// File: rtl/alu_bitserial_seq_pkg.sv
// Shared definitions for the bit-serial ALU: op codes, FSM states and
// small helpers used by both the 1-bit slice and the sequencer.
package alu_bitserial_seq_pkg;

    // ALU op codes. Code 1 is unassigned and is passed through to the slice as-is.
    typedef enum logic [2:0] {
        OP_UADD  = 3'd0,
        OP_UNDEF = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_AND   = 3'd4,
        OP_OR    = 3'd5,
        OP_NOR   = 3'd6,
        OP_XOR   = 3'd7
    } alu_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Logic ops live in the upper half of the op space.
    function automatic logic isLogicOp(input alu_op_e op);
        return op[2];
    endfunction

    // Only ADD and SUB report two's-complement overflow.
    function automatic logic isSignedArith(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_bitserial_seq_alu1.sv
// One-bit ALU slice. SUB is realised by inverting B here; the caller seeds
// the carry with 1 so that A + ~B + 1 = A - B across the serial stream.
module alu_bitserial_seq_alu1
    import alu_bitserial_seq_pkg::*;
(
    input  logic    a_i,
    input  logic    b_i,
    input  logic    carry_i,
    input  alu_op_e control_i,
    output logic    result_o,
    output logic    carry_o
);

    logic bEff;

    // Full adder for arithmetic ops, bitwise function for logic ops.
    always_comb begin
        bEff     = b_i ^ (control_i == OP_SUB);
        carry_o  = (a_i & bEff) | (a_i & carry_i) | (bEff & carry_i);
        result_o = a_i ^ bEff ^ carry_i;
        if (isLogicOp(control_i)) begin
            case (control_i[1:0])
                2'b00:   result_o = a_i & b_i;
                2'b01:   result_o = a_i | b_i;
                2'b10:   result_o = ~(a_i | b_i);
                default: result_o = a_i ^ b_i;
            endcase
        end
    end

endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU front end. Latches a WIDTH-bit operand pair and op, then
// feeds one bit pair per cycle (LSB first) through a single 1-bit slice,
// carrying between cycles, and presents the result and flags in DONE.
module alu_bitserial_seq
    import alu_bitserial_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    alu_op_e          op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carryout_q, carryout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;

    logic sliceSum;
    logic sliceCarry;

    alu_bitserial_seq_alu1 alu1 (
        .a_i       (a_q[idx_q]),
        .b_i       (b_q[idx_q]),
        .carry_i   (carry_q),
        .control_i (op_q),
        .result_o  (sliceSum),
        .carry_o   (sliceCarry)
    );

    // Next-state logic: accept in IDLE, shift one slice bit per RUN cycle, hold in DONE.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        result_d   = result_q;
        carryout_d = carryout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        negative_d = negative_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = alu_op_e'(op);
                    idx_d   = '0;
                    carry_d = op[0];
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Right-shift assembly: after WIDTH shifts bit 0 lands at position 0.
                result_d = {sliceSum, result_q[WIDTH-1:1]};
                carry_d  = sliceCarry;
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // carry_q here is still the carry into the MSB slice.
                    carryout_d = isLogicOp(op_q) ? 1'b0 : sliceCarry;
                    if (isLogicOp(op_q)) begin
                        overflow_d = 1'b0;
                    end else if (isSignedArith(op_q)) begin
                        overflow_d = carry_q ^ sliceCarry;
                    end else begin
                        overflow_d = sliceCarry;
                    end
                    zero_d     = (result_d == '0);
                    negative_d = sliceSum;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset that abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_UADD;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            result_q   <= result_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign carryout  = carryout_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Directed bench for the bit-serial ALU with hand-computed expectations.
module tb_alu_bitserial_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;
    logic             negative;

    int checkCount = 0;
    int errorCount = 0;

    int   cyc;
    int   accepted;
    int   got;
    int   lastDone;
    logic prevReady;
    logic [WIDTH-1:0] heldResult;

    logic [WIDTH-1:0] vecA [3] = '{32'h0000_0001, 32'h0000_0100, 32'hFFFF_FFFF};
    logic [WIDTH-1:0] vecB [3] = '{32'h0000_0002, 32'h0000_0200, 32'hFFFF_FFFF};
    logic [WIDTH-1:0] vecR [3] = '{32'h0000_0003, 32'h0000_0300, 32'hFFFF_FFFE};

    alu_bitserial_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic [WIDTH-1:0] expResult,
                               input logic expCarry, input logic expOvf,
                               input logic expZero, input logic expNeg);
        checkOutput({tag, "/out_valid"}, WIDTH'(out_valid), 1);
        checkOutput({tag, "/result"},    result,            expResult);
        checkOutput({tag, "/carryout"},  WIDTH'(carryout),  WIDTH'(expCarry));
        checkOutput({tag, "/overflow"},  WIDTH'(overflow),  WIDTH'(expOvf));
        checkOutput({tag, "/zero"},      WIDTH'(zero),      WIDTH'(expZero));
        checkOutput({tag, "/negative"},  WIDTH'(negative),  WIDTH'(expNeg));
    endtask

    // Present one operation, scramble the inputs after acceptance, and time the result.
    task automatic applyStimulus(input string tag, input logic [2:0] opv,
                                 input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        int waitCycles;
        int latency;
        waitCycles = 0;
        while (!in_ready && waitCycles < 100) begin
            tick();
            waitCycles++;
        end
        checkOutput({tag, "/readyBeforeAccept"}, WIDTH'(in_ready), 1);
        op = opv;
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 3'($urandom_range(7));
        checkOutput({tag, "/readyInRun"}, WIDTH'(in_ready), 0);
        latency = 0;
        while (!out_valid && latency < 100) begin
            tick();
            latency++;
        end
        checkOutput({tag, "/latency"}, WIDTH'(latency), WIDTH);
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "/readyAfterHandoff"}, WIDTH'(in_ready), 1);
        checkOutput({tag, "/validAfterHandoff"}, WIDTH'(out_valid), 0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        op = 3'd0;
        repeat (2) tick();
        checkOutput("reset/in_ready",  WIDTH'(in_ready),  1);
        checkOutput("reset/out_valid", WIDTH'(out_valid), 0);
        checkOutput("reset/result",    result,            0);
        checkOutput("reset/carryout",  WIDTH'(carryout),  0);
        checkOutput("reset/overflow",  WIDTH'(overflow),  0);
        checkOutput("reset/zero",      WIDTH'(zero),      0);
        checkOutput("reset/negative",  WIDTH'(negative),  0);
        reset = 1'b0;
        tick();

        // Signed overflow from max positive + 1.
        applyStimulus("addOvf", 3'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        checkResult("addOvf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        handoff("addOvf");

        applyStimulus("subEq", 3'd3, 32'd5, 32'd5);
        checkResult("subEq", 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        handoff("subEq");

        applyStimulus("subNeg", 3'd3, 32'd0, 32'd1);
        checkResult("subNeg", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        handoff("subNeg");

        applyStimulus("uaddWrap", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        checkResult("uaddWrap", 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
        handoff("uaddWrap");

        applyStimulus("nor", 3'd6, 32'h0000_0000, 32'h0000_0000);
        checkResult("nor", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        handoff("nor");

        // Consumer stalls for 10 cycles while new requests are offered.
        applyStimulus("andHold", 3'd4, 32'h1234_5678, 32'h0F0F_0F0F);
        checkResult("andHold", 32'h0204_0608, 1'b0, 1'b0, 1'b0, 1'b0);
        heldResult = 32'h0204_0608;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            op = 3'($urandom_range(7));
            tick();
            checkOutput("hold/result",    result,             heldResult);
            checkOutput("hold/out_valid", WIDTH'(out_valid),  1);
            checkOutput("hold/in_ready",  WIDTH'(in_ready),   0);
        end
        in_valid = 1'b0;
        handoff("andHold");

        // Abort an OR while bit 15 is in the slice.
        op = 3'd5;
        a = 32'hAAAA_AAAA;
        b = 32'h5555_0000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort/in_ready",  WIDTH'(in_ready),  1);
        checkOutput("abort/out_valid", WIDTH'(out_valid), 0);
        checkOutput("abort/result",    result,            0);

        applyStimulus("xor", 3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00);
        checkResult("xor", 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        handoff("xor");

        // Streaming: out_ready tied high, in_valid held until three ops are accepted.
        op = 3'd2;
        a = vecA[0];
        b = vecB[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        prevReady = in_ready;
        accepted = 0;
        got = 0;
        cyc = 0;
        lastDone = 0;
        while (got < 3 && cyc < 300) begin
            tick();
            cyc++;
            if (prevReady && in_valid) begin
                accepted++;
                if (accepted < 3) begin
                    a = vecA[accepted];
                    b = vecB[accepted];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                checkOutput("stream/result", result, vecR[got]);
                if (got > 0) begin
                    checkOutput("stream/period", WIDTH'(cyc - lastDone), WIDTH + 2);
                end
                lastDone = cyc;
                got++;
            end
            prevReady = in_ready;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("stream/resultsSeen", WIDTH'(got), 3);
        checkOutput("stream/accepted",    WIDTH'(accepted), 3);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
